axi_chan_comparator: RTL and testbench

- Single-clock, synthesizable AXI4 scoreboard that watches two AXI ports carrying the same traffic: port A upstream and port B downstream of a transport path, e.g. a NoC chimney pair.
- Per channel, it records each beat handshaked on the producing side in order and checks it against the beat handshaked on the consuming side.
- Request channels AW, W and AR are produced on A and consumed on B. Response channels B and R are produced on B and consumed on A.
- It drives no AXI signals and only reports mismatches, underflows and overflows.

---
 rtl/axi_chan_comparator_pkg.sv | 79 +++++++
 rtl/axi_chan_comparator_if.sv | 15 +
 rtl/axi_chan_comparator_ch.sv | 125 ++++++++++++
 rtl/axi_chan_comparator.sv | 173 +++++++++++++++++
 tb/tb_axi_chan_comparator.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_chan_comparator_pkg.sv
// Shared constants and default AXI channel/bundle types for the AXI channel comparator.
// Channel indices fix the bit order of every per-channel status vector.
package axi_chan_comparator_pkg;

    localparam int unsigned ChAw  = 0;
    localparam int unsigned ChW   = 1;
    localparam int unsigned ChB   = 2;
    localparam int unsigned ChAr  = 3;
    localparam int unsigned ChR   = 4;
    localparam int unsigned NumCh = 5;

    localparam int unsigned ErrCntWidth = 16;
    // Error sources per channel: {overflow, underflow, mismatch}.
    localparam int unsigned ErrPerCh    = 3;

    localparam int unsigned AxiIdW   = 4;
    localparam int unsigned AxiAddrW = 32;
    localparam int unsigned AxiDataW = 64;
    localparam int unsigned AxiUserW = 1;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [AxiDataW-1:0]   data;
        logic [AxiDataW/8-1:0] strb;
        logic                  last;
        logic [AxiUserW-1:0]   user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [1:0]          resp;
        logic [AxiUserW-1:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiDataW-1:0] data;
        logic [1:0]          resp;
        logic                last;
        logic [AxiUserW-1:0] user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        axi_b_chan_t  b;
        logic         b_valid;
        axi_r_chan_t  r;
        logic         r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_chan_comparator_if.sv
// One AXI port (request + response bundle) as seen by a master, a slave or a passive monitor.
// Handshake: a beat transfers on a channel in every cycle where its valid and ready are both high.
interface axi_chan_comparator_if
    import axi_chan_comparator_pkg::*;
#(
    parameter type req_t  = axi_req_t,
    parameter type resp_t = axi_resp_t
);
    req_t  req;
    resp_t rsp;

    modport master  (output req, input  rsp);
    modport slave   (input  req, output rsp);
    modport monitor (input  req, input  rsp);
endinterface

// File: rtl/axi_chan_comparator_ch.sv
// One channel of the comparator: in-order FIFO of produced beats, bypass, masked compare, sticky flags.
// Define AXI_CHAN_COMPARATOR_LOG_EN to get simulation-only $error reporting per event.
module axi_chan_comparator_ch
    import axi_chan_comparator_pkg::*;
#(
    parameter type         data_t    = logic,
    parameter int unsigned FifoDepth = 16,
    parameter data_t       MaskId    = '0
`ifdef AXI_CHAN_COMPARATOR_LOG_EN
   ,parameter string       ChName    = "ch"
`else
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  data_t               push_data_i,
    input  logic                pop_i,
    input  data_t               pop_data_i,
    output logic                mismatch_o,
    output logic                underflow_o,
    output logic                overflow_o,
    output logic                pending_o,
    output logic [ErrPerCh-1:0] err_o
);

    localparam int unsigned IdxW     = $clog2(FifoDepth);
    localparam int unsigned PayloadW = $bits(data_t);
    localparam logic [PayloadW-1:0] MaskVec = MaskId;

    typedef logic [IdxW:0] ptr_t;

    data_t r_mem [FifoDepth];
    ptr_t  r_wr_ptr;
    ptr_t  r_rd_ptr;
    logic  r_mismatch;
    logic  r_underflow;
    logic  r_overflow;

    logic                w_empty;
    logic                w_full;
    logic                w_bypass;
    logic                w_do_push;
    logic                w_do_pop;
    logic                w_ev_mis;
    logic                w_ev_unf;
    logic                w_ev_ovf;
    data_t               w_exp;
    logic [PayloadW-1:0] w_exp_vec;
    logic [PayloadW-1:0] w_act_vec;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IdxW-1:0] == r_rd_ptr[IdxW-1:0]) &&
                     (r_wr_ptr[IdxW] != r_rd_ptr[IdxW]);

    // Empty FIFO with both sides active: compare straight through, never store.
    assign w_bypass  = push_i && pop_i && w_empty;
    assign w_do_pop  = pop_i && !w_empty;
    assign w_do_push = push_i && !w_bypass && (!w_full || pop_i);
    assign w_ev_unf  = pop_i && !push_i && w_empty;
    assign w_ev_ovf  = push_i && !pop_i && w_full;

    assign w_exp     = w_bypass ? push_data_i : r_mem[r_rd_ptr[IdxW-1:0]];
    assign w_exp_vec = w_exp;
    assign w_act_vec = pop_data_i;
    assign w_ev_mis  = (w_do_pop || w_bypass) &&
                       (((w_exp_vec ^ w_act_vec) & ~MaskVec) != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mismatch  <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_mismatch  <= r_mismatch  | w_ev_mis;
            r_underflow <= r_underflow | w_ev_unf;
            r_overflow  <= r_overflow  | w_ev_ovf;
        end
    end

    // When full, the head is read combinationally before the same slot is overwritten.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_do_push) begin
            r_mem[r_wr_ptr[IdxW-1:0]] <= push_data_i;
        end
    end

    assign mismatch_o  = r_mismatch;
    assign underflow_o = r_underflow;
    assign overflow_o  = r_overflow;
    assign pending_o   = !w_empty;
    assign err_o       = {w_ev_ovf, w_ev_unf, w_ev_mis};

`ifdef AXI_CHAN_COMPARATOR_LOG_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_ev_mis) begin
                $error("%s mismatch at %0t: expected %h actual %h", ChName, $time, w_exp, pop_data_i);
            end
            if (w_ev_unf) begin
                $error("%s underflow at %0t: expected nothing, actual %h", ChName, $time, pop_data_i);
            end
            if (w_ev_ovf) begin
                $error("%s overflow at %0t: FIFO full, dropped %h", ChName, $time, push_data_i);
            end
        end
    end

    final begin
        if (pending_o) begin
            $display("%s: %0d beats still pending at end of simulation", ChName, r_wr_ptr - r_rd_ptr);
        end
    end
`else
`endif

endmodule

// File: rtl/axi_chan_comparator.sv
// Passive AXI4 scoreboard comparing port A (upstream) against port B (downstream), one checker per channel.
// Define AXI_CHAN_COMPARATOR_LOG_EN for simulation-only $error reporting of every error event.
module axi_chan_comparator
    import axi_chan_comparator_pkg::*;
#(
    parameter bit          IgnoreId  = 1'b0,
    parameter int unsigned FifoDepth = 16,
    parameter type         aw_chan_t = axi_aw_chan_t,
    parameter type         w_chan_t  = axi_w_chan_t,
    parameter type         b_chan_t  = axi_b_chan_t,
    parameter type         ar_chan_t = axi_ar_chan_t,
    parameter type         r_chan_t  = axi_r_chan_t,
    parameter type         req_t     = axi_req_t,
    parameter type         resp_t    = axi_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  req_t                   axi_a_req_i,
    input  resp_t                  axi_a_rsp_i,
    input  req_t                   axi_b_req_i,
    input  resp_t                  axi_b_rsp_i,
    output logic [NumCh-1:0]       mismatch_o,
    output logic [NumCh-1:0]       underflow_o,
    output logic [NumCh-1:0]       overflow_o,
    output logic [NumCh-1:0]       pending_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam int unsigned SumW  = $clog2(NumCh * ErrPerCh + 1);
    localparam int unsigned CntW1 = ErrCntWidth + 1;

    function automatic aw_chan_t aw_id_mask(input bit en);
        aw_chan_t m;
        m = '0;
        if (en) m.id = '1;
        return m;
    endfunction

    function automatic ar_chan_t ar_id_mask(input bit en);
        ar_chan_t m;
        m = '0;
        if (en) m.id = '1;
        return m;
    endfunction

    function automatic b_chan_t b_id_mask(input bit en);
        b_chan_t m;
        m = '0;
        if (en) m.id = '1;
        return m;
    endfunction

    function automatic r_chan_t r_id_mask(input bit en);
        r_chan_t m;
        m = '0;
        if (en) m.id = '1;
        return m;
    endfunction

    localparam aw_chan_t AwMask = aw_id_mask(IgnoreId);
    localparam ar_chan_t ArMask = ar_id_mask(IgnoreId);
    localparam b_chan_t  BMask  = b_id_mask(IgnoreId);
    localparam r_chan_t  RMask  = r_id_mask(IgnoreId);

    logic [NumCh-1:0]                w_push;
    logic [NumCh-1:0]                w_pop;
    logic [NumCh-1:0][ErrPerCh-1:0]  w_err;
    logic [SumW-1:0]                 w_err_sum;
    logic [CntW1-1:0]                w_cnt_next;
    logic [ErrCntWidth-1:0]          r_err_cnt;

    // Requests are produced on A and consumed on B; responses flow the other way.
    assign w_push[ChAw] = axi_a_req_i.aw_valid && axi_a_rsp_i.aw_ready;
    assign w_pop[ChAw]  = axi_b_req_i.aw_valid && axi_b_rsp_i.aw_ready;
    assign w_push[ChW]  = axi_a_req_i.w_valid  && axi_a_rsp_i.w_ready;
    assign w_pop[ChW]   = axi_b_req_i.w_valid  && axi_b_rsp_i.w_ready;
    assign w_push[ChAr] = axi_a_req_i.ar_valid && axi_a_rsp_i.ar_ready;
    assign w_pop[ChAr]  = axi_b_req_i.ar_valid && axi_b_rsp_i.ar_ready;
    assign w_push[ChB]  = axi_b_rsp_i.b_valid  && axi_b_req_i.b_ready;
    assign w_pop[ChB]   = axi_a_rsp_i.b_valid  && axi_a_req_i.b_ready;
    assign w_push[ChR]  = axi_b_rsp_i.r_valid  && axi_b_req_i.r_ready;
    assign w_pop[ChR]   = axi_a_rsp_i.r_valid  && axi_a_req_i.r_ready;

    axi_chan_comparator_ch #(
        .data_t(aw_chan_t), .FifoDepth(FifoDepth), .MaskId(AwMask)
`ifdef AXI_CHAN_COMPARATOR_LOG_EN
       ,.ChName("AW")
`endif
    ) u_ch_aw (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(w_push[ChAw]), .push_data_i(axi_a_req_i.aw),
        .pop_i(w_pop[ChAw]), .pop_data_i(axi_b_req_i.aw),
        .mismatch_o(mismatch_o[ChAw]), .underflow_o(underflow_o[ChAw]),
        .overflow_o(overflow_o[ChAw]), .pending_o(pending_o[ChAw]), .err_o(w_err[ChAw])
    );

    axi_chan_comparator_ch #(
        .data_t(w_chan_t), .FifoDepth(FifoDepth), .MaskId('0)
`ifdef AXI_CHAN_COMPARATOR_LOG_EN
       ,.ChName("W")
`endif
    ) u_ch_w (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(w_push[ChW]), .push_data_i(axi_a_req_i.w),
        .pop_i(w_pop[ChW]), .pop_data_i(axi_b_req_i.w),
        .mismatch_o(mismatch_o[ChW]), .underflow_o(underflow_o[ChW]),
        .overflow_o(overflow_o[ChW]), .pending_o(pending_o[ChW]), .err_o(w_err[ChW])
    );

    axi_chan_comparator_ch #(
        .data_t(b_chan_t), .FifoDepth(FifoDepth), .MaskId(BMask)
`ifdef AXI_CHAN_COMPARATOR_LOG_EN
       ,.ChName("B")
`endif
    ) u_ch_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(w_push[ChB]), .push_data_i(axi_b_rsp_i.b),
        .pop_i(w_pop[ChB]), .pop_data_i(axi_a_rsp_i.b),
        .mismatch_o(mismatch_o[ChB]), .underflow_o(underflow_o[ChB]),
        .overflow_o(overflow_o[ChB]), .pending_o(pending_o[ChB]), .err_o(w_err[ChB])
    );

    axi_chan_comparator_ch #(
        .data_t(ar_chan_t), .FifoDepth(FifoDepth), .MaskId(ArMask)
`ifdef AXI_CHAN_COMPARATOR_LOG_EN
       ,.ChName("AR")
`endif
    ) u_ch_ar (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(w_push[ChAr]), .push_data_i(axi_a_req_i.ar),
        .pop_i(w_pop[ChAr]), .pop_data_i(axi_b_req_i.ar),
        .mismatch_o(mismatch_o[ChAr]), .underflow_o(underflow_o[ChAr]),
        .overflow_o(overflow_o[ChAr]), .pending_o(pending_o[ChAr]), .err_o(w_err[ChAr])
    );

    axi_chan_comparator_ch #(
        .data_t(r_chan_t), .FifoDepth(FifoDepth), .MaskId(RMask)
`ifdef AXI_CHAN_COMPARATOR_LOG_EN
       ,.ChName("R")
`endif
    ) u_ch_r (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(w_push[ChR]), .push_data_i(axi_b_rsp_i.r),
        .pop_i(w_pop[ChR]), .pop_data_i(axi_a_rsp_i.r),
        .mismatch_o(mismatch_o[ChR]), .underflow_o(underflow_o[ChR]),
        .overflow_o(overflow_o[ChR]), .pending_o(pending_o[ChR]), .err_o(w_err[ChR])
    );

    always_comb begin
        w_err_sum = '0;
        for (int c = 0; c < NumCh; c++) begin
            for (int e = 0; e < ErrPerCh; e++) begin
                w_err_sum = w_err_sum + SumW'(w_err[c][e]);
            end
        end
    end

    // One extra bit catches the carry so the counter can clamp at all-ones.
    assign w_cnt_next = {1'b0, r_err_cnt} + CntW1'(w_err_sum);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_cnt_next[ErrCntWidth]) begin
            r_err_cnt <= '1;
        end else begin
            r_err_cnt <= w_cnt_next[ErrCntWidth-1:0];
        end
    end

    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_axi_chan_comparator.sv
// Directed bench for axi_chan_comparator: three instances (exact ids, ignored ids, depth 4) watch one A/B port pair.
module tb_axi_chan_comparator;
    import axi_chan_comparator_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_assert;
    int unsigned n_fail;

    axi_chan_comparator_if a_if ();
    axi_chan_comparator_if b_if ();

    logic [NumCh-1:0] d0_mis, d0_unf, d0_ovf, d0_pnd;
    logic [NumCh-1:0] ig_mis, ig_unf, ig_ovf, ig_pnd;
    logic [NumCh-1:0] d4_mis, d4_unf, d4_ovf, d4_pnd;
    logic [15:0]      d0_err, ig_err, d4_err;

    axi_chan_comparator #(.IgnoreId(1'b0), .FifoDepth(16)) u_d0 (
        .clk_i(clk), .rst_i(rst),
        .axi_a_req_i(a_if.req), .axi_a_rsp_i(a_if.rsp),
        .axi_b_req_i(b_if.req), .axi_b_rsp_i(b_if.rsp),
        .mismatch_o(d0_mis), .underflow_o(d0_unf), .overflow_o(d0_ovf),
        .pending_o(d0_pnd), .err_cnt_o(d0_err)
    );

    axi_chan_comparator #(.IgnoreId(1'b1), .FifoDepth(16)) u_ig (
        .clk_i(clk), .rst_i(rst),
        .axi_a_req_i(a_if.req), .axi_a_rsp_i(a_if.rsp),
        .axi_b_req_i(b_if.req), .axi_b_rsp_i(b_if.rsp),
        .mismatch_o(ig_mis), .underflow_o(ig_unf), .overflow_o(ig_ovf),
        .pending_o(ig_pnd), .err_cnt_o(ig_err)
    );

    axi_chan_comparator #(.IgnoreId(1'b0), .FifoDepth(4)) u_d4 (
        .clk_i(clk), .rst_i(rst),
        .axi_a_req_i(a_if.req), .axi_a_rsp_i(a_if.rsp),
        .axi_b_req_i(b_if.req), .axi_b_rsp_i(b_if.rsp),
        .mismatch_o(d4_mis), .underflow_o(d4_unf), .overflow_o(d4_ovf),
        .pending_o(d4_pnd), .err_cnt_o(d4_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_if.req = '0;
        b_if.req = '0;
        a_if.rsp = '0;
        b_if.rsp = '0;
        a_if.req.b_ready  = 1'b1;
        a_if.req.r_ready  = 1'b1;
        b_if.req.b_ready  = 1'b1;
        b_if.req.r_ready  = 1'b1;
        a_if.rsp.aw_ready = 1'b1;
        a_if.rsp.w_ready  = 1'b1;
        a_if.rsp.ar_ready = 1'b1;
        b_if.rsp.aw_ready = 1'b1;
        b_if.rsp.w_ready  = 1'b1;
        b_if.rsp.ar_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic axi_aw_chan_t mk_aw(input logic [3:0] id, input logic [31:0] addr);
        axi_aw_chan_t p;
        p = '0;
        p.id = id; p.addr = addr; p.size = 3'd3; p.burst = 2'b01;
        return p;
    endfunction

    function automatic axi_ar_chan_t mk_ar(input logic [3:0] id, input logic [31:0] addr);
        axi_ar_chan_t p;
        p = '0;
        p.id = id; p.addr = addr; p.size = 3'd3; p.burst = 2'b01;
        return p;
    endfunction

    function automatic axi_w_chan_t mk_w(input logic [63:0] data, input logic last);
        axi_w_chan_t p;
        p = '0;
        p.data = data; p.strb = 8'hFF; p.last = last;
        return p;
    endfunction

    function automatic axi_b_chan_t mk_b(input logic [3:0] id, input logic [1:0] resp);
        axi_b_chan_t p;
        p = '0;
        p.id = id; p.resp = resp;
        return p;
    endfunction

    function automatic axi_r_chan_t mk_r(input logic [3:0] id, input logic [63:0] data);
        axi_r_chan_t p;
        p = '0;
        p.id = id; p.data = data; p.last = 1'b1;
        return p;
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_mismatch",  32'(d0_mis), 32'h0);
        chk("rst_underflow", 32'(d0_unf), 32'h0);
        chk("rst_overflow",  32'(d0_ovf), 32'h0);
        chk("rst_pending",   32'(d0_pnd), 32'h0);
        chk("rst_err_cnt",   32'(d0_err), 32'h0);

        // 100 beats per channel, consuming side one cycle behind the producing side.
        for (int i = 0; i <= 100; i++) begin
            idle();
            if (i < 100) begin
                a_if.req.aw_valid = 1'b1; a_if.req.aw = mk_aw(4'(i), 32'(i) * 32'h10);
                a_if.req.w_valid  = 1'b1; a_if.req.w  = mk_w(64'(i) * 64'h0101, i[0]);
                a_if.req.ar_valid = 1'b1; a_if.req.ar = mk_ar(4'(i + 1), 32'h8000 + 32'(i) * 32'h4);
                b_if.rsp.b_valid  = 1'b1; b_if.rsp.b  = mk_b(4'(i), 2'(i));
                b_if.rsp.r_valid  = 1'b1; b_if.rsp.r  = mk_r(4'(i), 64'(i) << 8);
            end
            if (i > 0) begin
                b_if.req.aw_valid = 1'b1; b_if.req.aw = mk_aw(4'(i - 1), 32'(i - 1) * 32'h10);
                b_if.req.w_valid  = 1'b1; b_if.req.w  = mk_w(64'(i - 1) * 64'h0101, ~i[0]);
                b_if.req.ar_valid = 1'b1; b_if.req.ar = mk_ar(4'(i), 32'h8000 + 32'(i - 1) * 32'h4);
                a_if.rsp.b_valid  = 1'b1; a_if.rsp.b  = mk_b(4'(i - 1), 2'(i - 1));
                a_if.rsp.r_valid  = 1'b1; a_if.rsp.r  = mk_r(4'(i - 1), 64'(i - 1) << 8);
            end
            tick();
            if (i == 0) begin
                chk("stream_pending_first", 32'(d0_pnd), 32'h1F);
            end
        end
        idle();
        chk("stream_mismatch",  32'(d0_mis), 32'h0);
        chk("stream_underflow", 32'(d0_unf), 32'h0);
        chk("stream_overflow",  32'(d0_ovf), 32'h0);
        chk("stream_pending",   32'(d0_pnd), 32'h0);
        chk("stream_err_cnt",   32'(d0_err), 32'h0);
        chk("stream_d4_err",    32'(d4_err), 32'h0);

        // AW id remapped by the path: only the exact-id instance objects.
        do_reset();
        a_if.req.aw_valid = 1'b1; a_if.req.aw = mk_aw(4'd2, 32'h100);
        tick();
        idle();
        b_if.req.aw_valid = 1'b1; b_if.req.aw = mk_aw(4'd5, 32'h100);
        #1;
        chk("id_mis_not_early", 32'(d0_mis), 32'h0);
        tick();
        idle();
        chk("id_ignored_mis", 32'(ig_mis), 32'h0);
        chk("id_ignored_err", 32'(ig_err), 32'h0);
        chk("id_exact_mis",   32'(d0_mis), 32'h01);
        chk("id_exact_err",   32'(d0_err), 32'h1);
        chk("id_pending",     32'(d0_pnd), 32'h0);
        a_if.req.ar_valid = 1'b1; a_if.req.ar = mk_ar(4'd1, 32'h200);
        tick();
        idle();
        b_if.req.ar_valid = 1'b1; b_if.req.ar = mk_ar(4'd1, 32'h204);
        tick();
        idle();
        chk("addr_ignored_mis", 32'(ig_mis), 32'h08);
        chk("addr_ignored_err", 32'(ig_err), 32'h1);
        chk("addr_exact_mis",   32'(d0_mis), 32'h09);
        chk("addr_exact_err",   32'(d0_err), 32'h2);

        // R data mismatch stays sticky through a later good beat.
        do_reset();
        b_if.rsp.r_valid = 1'b1; b_if.rsp.r = mk_r(4'd3, 64'hA5);
        tick();
        idle();
        a_if.rsp.r_valid = 1'b1; a_if.rsp.r = mk_r(4'd3, 64'hA4);
        tick();
        idle();
        chk("r_mis",     32'(d0_mis), 32'h10);
        chk("r_mis_err", 32'(d0_err), 32'h1);
        b_if.rsp.r_valid = 1'b1; b_if.rsp.r = mk_r(4'd3, 64'h77);
        tick();
        idle();
        a_if.rsp.r_valid = 1'b1; a_if.rsp.r = mk_r(4'd3, 64'h77);
        tick();
        idle();
        tick();
        chk("r_mis_sticky", 32'(d0_mis), 32'h10);
        chk("r_err_stable", 32'(d0_err), 32'h1);
        chk("r_pending",    32'(d0_pnd), 32'h0);

        // AR underflow, then same-cycle bypass with equal and unequal payloads.
        do_reset();
        b_if.req.ar_valid = 1'b1; b_if.req.ar = mk_ar(4'd7, 32'h300);
        b_if.rsp.ar_ready = 1'b0;
        tick();
        idle();
        chk("ar_no_handshake_unf", 32'(d0_unf), 32'h0);
        b_if.req.ar_valid = 1'b1; b_if.req.ar = mk_ar(4'd7, 32'h300);
        tick();
        idle();
        chk("ar_unf",     32'(d0_unf), 32'h08);
        chk("ar_unf_err", 32'(d0_err), 32'h1);
        chk("ar_unf_pnd", 32'(d0_pnd), 32'h0);
        chk("ar_unf_mis", 32'(d0_mis), 32'h0);
        a_if.req.ar_valid = 1'b1; a_if.req.ar = mk_ar(4'd2, 32'h400);
        b_if.req.ar_valid = 1'b1; b_if.req.ar = mk_ar(4'd2, 32'h400);
        tick();
        idle();
        chk("bypass_eq_unf", 32'(d0_unf), 32'h08);
        chk("bypass_eq_mis", 32'(d0_mis), 32'h0);
        chk("bypass_eq_err", 32'(d0_err), 32'h1);
        chk("bypass_eq_pnd", 32'(d0_pnd), 32'h0);
        a_if.req.aw_valid = 1'b1; a_if.req.aw = mk_aw(4'd1, 32'h500);
        b_if.req.aw_valid = 1'b1; b_if.req.aw = mk_aw(4'd1, 32'h504);
        tick();
        idle();
        chk("bypass_ne_mis", 32'(d0_mis), 32'h01);
        chk("bypass_ne_err", 32'(d0_err), 32'h2);
        chk("bypass_ne_pnd", 32'(d0_pnd), 32'h0);

        // Depth-4 W FIFO: fill, push-while-full with consume, then a dropped push.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            a_if.req.w_valid = 1'b1; a_if.req.w = mk_w(64'h1000 + 64'(k), k == 3);
            tick();
        end
        idle();
        chk("w_full_pnd", 32'(d4_pnd), 32'h02);
        chk("w_full_ovf", 32'(d4_ovf), 32'h0);
        a_if.req.w_valid = 1'b1; a_if.req.w = mk_w(64'h1004, 1'b0);
        b_if.req.w_valid = 1'b1; b_if.req.w = mk_w(64'h1000, 1'b0);
        tick();
        idle();
        chk("w_full_swap_ovf", 32'(d4_ovf), 32'h0);
        chk("w_full_swap_mis", 32'(d4_mis), 32'h0);
        chk("w_full_swap_err", 32'(d4_err), 32'h0);
        a_if.req.w_valid = 1'b1; a_if.req.w = mk_w(64'h1005, 1'b0);
        tick();
        idle();
        chk("w_ovf",        32'(d4_ovf), 32'h02);
        chk("w_ovf_err",    32'(d4_err), 32'h1);
        chk("w_ovf_pnd",    32'(d4_pnd), 32'h02);
        chk("w_deep_noovf", 32'(d0_ovf), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            idle();
            b_if.req.w_valid = 1'b1; b_if.req.w = mk_w(64'h1000 + 64'(k), k == 3);
            tick();
        end
        idle();
        chk("w_drain_mis", 32'(d4_mis), 32'h0);
        chk("w_drain_pnd", 32'(d4_pnd), 32'h0);
        chk("w_drain_err", 32'(d4_err), 32'h1);
        chk("w_deep_pnd",  32'(d0_pnd), 32'h02);

        // Reset with AW entries pending; handshakes during reset are ignored.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            a_if.req.aw_valid = 1'b1; a_if.req.aw = mk_aw(4'(k), 32'h600 + 32'(k) * 32'h4);
            tick();
        end
        idle();
        chk("aw_pending_pre_rst", 32'(d0_pnd), 32'h01);
        rst = 1'b1;
        a_if.req.aw_valid = 1'b1; a_if.req.aw = mk_aw(4'd9, 32'h700);
        tick();
        tick();
        rst = 1'b0;
        idle();
        tick();
        chk("post_rst_pnd", 32'(d0_pnd), 32'h0);
        chk("post_rst_mis", 32'(d0_mis), 32'h0);
        chk("post_rst_unf", 32'(d0_unf), 32'h0);
        chk("post_rst_err", 32'(d0_err), 32'h0);
        b_if.req.aw_valid = 1'b1; b_if.req.aw = mk_aw(4'd0, 32'h600);
        tick();
        idle();
        chk("post_rst_aw_unf", 32'(d0_unf), 32'h01);
        chk("post_rst_aw_err", 32'(d0_err), 32'h1);
        a_if.req.aw_valid = 1'b1; a_if.req.aw = mk_aw(4'd1, 32'h800);
        a_if.rsp.aw_ready = 1'b0;
        tick();
        idle();
        chk("aw_not_ready_pnd", 32'(d0_pnd), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
